// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin, age-aware arbitration of two writeback channels onto one registered regfile write port.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 regWrite,
  output logic [ADDR_W-1:0]    writeReg,
  output logic [DATA_W-1:0]    writeData,
  output logic [2**ADDR_W-1:0] pending
);
  localparam int NR = 2**ADDR_W;
  logic ha_v_q, ha_v_d, hb_v_q, hb_v_d, a_older_q, a_older_d, rr_b_q, rr_b_d, we_q, we_d;
  logic [ADDR_W-1:0] ha_addr_q, ha_addr_d, hb_addr_q, hb_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] ha_data_q, ha_data_d, hb_data_q, hb_data_d, wr_data_q, wr_data_d;
  logic ga, gb, a_ld, b_ld;
  // same-address pairs are ordered by age; otherwise the round-robin pointer decides
  always_comb begin
    ga = ha_v_q && (!hb_v_q || ((ha_addr_q == hb_addr_q) ? a_older_q : !rr_b_q));
    gb = hb_v_q && !ga;
    a_ready = !ha_v_q || ga;
    b_ready = !hb_v_q || gb;
    a_ld = a_valid && a_ready;
    b_ld = b_valid && b_ready;
    ha_v_d = a_ld || (ha_v_q && !ga);
    hb_v_d = b_ld || (hb_v_q && !gb);
    ha_addr_d = a_ld ? a_addr : ha_addr_q;
    ha_data_d = a_ld ? a_data : ha_data_q;
    hb_addr_d = b_ld ? b_addr : hb_addr_q;
    hb_data_d = b_ld ? b_data : hb_data_q;
    a_older_d = (ha_v_q && !ga && b_ld) ? 1'b1 : a_ld ? 1'b0 : a_older_q;
    rr_b_d = ga ? 1'b1 : gb ? 1'b0 : rr_b_q;
    wr_addr_d = ga ? ha_addr_q : gb ? hb_addr_q : wr_addr_q;
    wr_data_d = ga ? ha_data_q : gb ? hb_data_q : wr_data_q;
    we_d = (ga || gb) && (wr_addr_d != '0);
  end
  always_comb begin
    pending = '0;
    for (int i = 1; i < NR; i++)
      pending[i] = (ha_v_q && ha_addr_q == ADDR_W'(i)) || (hb_v_q && hb_addr_q == ADDR_W'(i)) ||
                   (we_q && wr_addr_q == ADDR_W'(i));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ha_v_q <= 1'b0;
      hb_v_q <= 1'b0;
      a_older_q <= 1'b0;
      rr_b_q <= 1'b0;
      we_q <= 1'b0;
      ha_addr_q <= '0;
      hb_addr_q <= '0;
      wr_addr_q <= '0;
      ha_data_q <= '0;
      hb_data_q <= '0;
      wr_data_q <= '0;
    end else begin
      ha_v_q <= ha_v_d;
      hb_v_q <= hb_v_d;
      a_older_q <= a_older_d;
      rr_b_q <= rr_b_d;
      we_q <= we_d;
      ha_addr_q <= ha_addr_d;
      hb_addr_q <= hb_addr_d;
      wr_addr_q <= wr_addr_d;
      ha_data_q <= ha_data_d;
      hb_data_q <= hb_data_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign regWrite = we_q;
  assign writeReg = wr_addr_q;
  assign writeData = wr_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: random and directed stimulus checked against a timestamp-based reference model.
module tb_regfile_wb_arbiter;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic a_valid = 0, b_valid = 0, a_ready, b_ready, regWrite;
  logic [4:0] a_addr = 0, b_addr = 0, writeReg;
  logic [31:0] a_data = 0, b_data = 0, writeData, pending;
  int checks = 0, passed = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData), .pending(pending)
  );

  // model: each hold keeps the cycle it was loaded; smaller stamp is older, ties go to B
  bit mav, mbv, m_next_b, mwe;
  logic [4:0] maa, mba, mwr;
  logic [31:0] mad, mbd, mwd;
  int mat, mbt, cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    mav = 0; mbv = 0; m_next_b = 0; mwe = 0;
    maa = 0; mba = 0; mwr = 0; mad = 0; mbd = 0; mwd = 0;
    mat = 0; mbt = 0;
  endtask

  task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [31:0] bd);
    bit ga, gb, ar, br;
    logic [31:0] ep;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    if (mav && mbv) gb = (maa == mba) ? (mbt <= mat) : m_next_b;
    else gb = mbv;
    ga = mav && !gb;
    ar = !mav || ga;
    br = !mbv || gb;
    ep = 0;
    if (mav) ep[maa] = 1;
    if (mbv) ep[mba] = 1;
    if (mwe) ep[mwr] = 1;
    ep[0] = 0;
    check("a_ready", a_ready, ar);
    check("b_ready", b_ready, br);
    check("regWrite", regWrite, mwe);
    check("writeReg", writeReg, mwr);
    check("writeData", writeData, mwd);
    check("pending", pending, ep);
    cyc++;
    if (ga) begin mwe = (maa != 0); mwr = maa; mwd = mad; m_next_b = 1; mav = 0; end
    else if (gb) begin mwe = (mba != 0); mwr = mba; mwd = mbd; m_next_b = 0; mbv = 0; end
    else mwe = 0;
    if (av && ar) begin mav = 1; maa = aa; mad = ad; mat = cyc; end
    if (bv && br) begin mbv = 1; mba = ba; mbd = bd; mbt = cyc; end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    a_valid = 0; b_valid = 0;
    #1;
    check("rst_regWrite", regWrite, 0);
    check("rst_writeReg", writeReg, 0);
    check("rst_writeData", writeData, 0);
    check("rst_pending", pending, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    #1;
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    @(negedge clk);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    do_reset();
    step(1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("single_pend_e0", pending[5], 1);
    check("single_we_e0", regWrite, 0);
    idle(1);
    check("single_we", regWrite, 1);
    check("single_reg", writeReg, 5);
    check("single_data", writeData, 32'hDEADBEEF);
    idle(1);
    check("single_pend_e2", pending[5], 0);
    do_reset();
    step(1, 3, 32'h11, 1, 4, 32'h22);
    idle(1);
    check("cont_first", {regWrite, writeReg, writeData}, {1'b1, 5'd3, 32'h11});
    idle(1);
    check("cont_second", {regWrite, writeReg, writeData}, {1'b1, 5'd4, 32'h22});
    step(1, 7, 32'hAAAA, 1, 7, 32'hBBBB);
    idle(1);
    check("same_first", writeData, 32'hBBBB);
    idle(1);
    check("same_second", {regWrite, writeReg, writeData}, {1'b1, 5'd7, 32'hAAAA});
    step(0, 0, 0, 1, 11, 32'h3);
    idle(2);
    step(1, 10, 32'h5, 1, 9, 32'h1);
    step(1, 9, 32'h2, 0, 0, 0);
    check("stag_a10", {writeReg, writeData}, {5'd10, 32'h5});
    idle(1);
    check("stag_b9", {writeReg, writeData}, {5'd9, 32'h1});
    idle(1);
    check("stag_a9", {writeReg, writeData}, {5'd9, 32'h2});
    idle(1);
    step(0, 0, 0, 1, 0, 32'hFFFFFFFF);
    idle(1);
    check("zero_we", regWrite, 0);
    check("zero_pend", pending, 0);
    step(0, 0, 0, 1, 6, 32'h7);
    idle(1);
    check("zero_next", {regWrite, writeReg, writeData}, {1'b1, 5'd6, 32'h7});
    for (int i = 0; i < 20; i++)
      step(1, 5'($urandom_range(1, 15)), $urandom, 1, 5'($urandom_range(16, 31)), $urandom);
    do_reset();
    idle(3);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom);
      if (i % 500 == 499) do_reset();
    end
    idle(3);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: channel A (ALU result) and channel B (load data from memory).
- Each channel has a valid/ready handshake and a one-entry holding register.
- A round-robin arbiter with a same-address ordering rule selects one channel per cycle. The winner drives a registered write port that feeds the register file's regWrite/writeReg/writeData inputs.
- Also exports a pending-write bitmap for the hazard/stall logic.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register index (2**ADDR_W registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  channel A request valid.
- a_ready  output  1  channel A can accept this cycle.
- a_addr  input  ADDR_W  channel A destination register.
- a_data  input  DATA_W  channel A write data.
- b_valid  input  1  channel B request valid.
- b_ready  output  1  channel B can accept this cycle.
- b_addr  input  ADDR_W  channel B destination register.
- b_data  input  DATA_W  channel B write data.
- regWrite  output  1  write enable to register file (registered).
- writeReg  output  ADDR_W  write address (registered).
- writeData  output  DATA_W  write data (registered).
- pending  output  2**ADDR_W  one bit per register with an uncommitted write.

Behaviour:
- Reset (async, rst_n low):
  - Both holding registers empty and age flag cleared.
  - Round-robin pointer set to A.
  - regWrite=0, writeReg=0, writeData=0, pending=0.
  - a_ready=1 and b_ready=1 once reset is released.
  - Reset mid-operation discards all held requests; no write is issued for them.
- Accept: a transfer on channel X occurs at a rising edge where X_valid && X_ready. addr/data are captured into hold_X and hold_X becomes valid.
- Ready:
  - X_ready = !hold_X_valid || grant_X.
  - A held entry granted this cycle frees its slot, so a new request is accepted on the same edge.
  - Ready never depends on X_valid.
- Grant (combinational, at most one per cycle):
  - Only A held: grant A. Only B held: grant B.
  - Both held, different addr: grant the channel selected by the RR pointer.
  - Both held, same addr: grant the older entry.
  - Age rule: an entry loaded while the other hold is already valid is younger. If both are loaded on the same edge, B is older, so A's value is final.
- RR pointer: after any grant it points to the channel not granted. It is unchanged when nothing is granted.
- Output stage: at the edge following the grant:
  - writeReg/writeData take the granted entry.
  - regWrite = 1 if the granted addr != 0, otherwise 0. Writes to $0 are consumed and dropped.
  - With no grant, regWrite=0 and writeReg/writeData hold their previous values.
- Latency: the handshake at edge E0 gives regWrite high in the cycle after edge E1 when uncontended. The register file commits at E2.
- Throughput: one write per cycle sustained. With both channels streaming distinct addresses, grants strictly alternate.
- pending:
  - Bit r is set if hold_A, hold_B, or the output stage with regWrite=1 targets r.
  - Bit 0 is always 0.
  - Combinational from state only, so it clears the cycle after regWrite drops for that address.
- No reordering of writes within a channel; both channels are in-order with depth 1.

Test Plan:
- Reset: assert rst_n=0 mid-stream with both holds full -> all outputs 0 immediately; a_ready=b_ready=1 after release; no regWrite pulse for the discarded entries.
- Single write: A sends addr=5, data=0xDEADBEEF at E0 -> pending[5]=1 after E0; regWrite=1, writeReg=5, writeData=0xDEADBEEF in the cycle after E1; pending[5]=0 after E2.
- Contention, distinct addresses: A(addr=3, 0x11) and B(addr=4, 0x22) on the same edge after reset -> A is written first, then B on the next cycle. Continuous streaming from both gives strictly alternating A, B, A, B grants; a_ready and b_ready never both low for more than 1 cycle.
- Same address: both channels target addr=7 on the same edge, A=0xAAAA, B=0xBBBB -> B is written first, then A; final register value 0xAAAA regardless of the RR pointer.
- Same address, staggered: B holds addr=9 (0x1) and is blocked by RR; A's addr=9 (0x2) arrives later -> B is written before A.
- $0 write: B sends addr=0, data=0xFFFFFFFF -> b_ready handshake completes, regWrite stays 0, pending stays 0, and the next request is accepted normally.
